// File: rtl/aes128_dec_key_sched.sv
// AES-128 decryption key schedule.
// Accepts a cipher key, expands all eleven round keys into a register file
// (one round per cycle), then streams them out in reverse order 10..0 over a
// valid/ready handshake so a decryption core can consume them last-first.
module aes128_dec_key_sched (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [0:127] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] rk,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

  // FIPS-197 forward S-box, entry 0 leftmost.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] store_q [0:10];
  logic [127:0] store_d [0:10];
  logic         key_ready_q, key_ready_d;
  logic         rk_valid_q, rk_valid_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rk_index_q, rk_index_d;
  logic         rk_last_q, rk_last_d;
  logic         busy_q, busy_d;

  logic [127:0] key_w;
  logic [3:0]   prev_sel, strm_sel;
  logic [127:0] prev_rk, strm_rk, next_rk;
  logic [31:0]  pw0, pw1, pw2, pw3, rot_w, sub_w, nw0, nw1, nw2, nw3;

  assign key_w    = key;
  assign prev_sel = rnd_q - 4'd1;
  assign strm_sel = idx_q - 4'd1;

  // Register-file read ports: previous round (expansion) and next-lower round (streaming).
  always_comb begin
    prev_rk = '0;
    strm_rk = '0;
    for (int i = 0; i < 11; i++) begin
      if (prev_sel == i[3:0]) prev_rk = store_q[i];
      if (strm_sel == i[3:0]) strm_rk = store_q[i];
    end
  end

  // One AES-128 key-expansion round: four S-box lookups on the rotated last word.
  always_comb begin
    pw0     = prev_rk[127:96];
    pw1     = prev_rk[95:64];
    pw2     = prev_rk[63:32];
    pw3     = prev_rk[31:0];
    rot_w   = {pw3[23:0], pw3[31:24]};
    sub_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    nw0     = pw0 ^ sub_w ^ {rcon(rnd_q), 24'h000000};
    nw1     = pw1 ^ nw0;
    nw2     = pw2 ^ nw1;
    nw3     = pw3 ^ nw2;
    next_rk = {nw0, nw1, nw2, nw3};
  end

  // Next-state and registered-output logic of the IDLE/EXPAND/STREAM controller.
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    idx_d       = idx_q;
    store_d     = store_q;
    key_ready_d = key_ready_q;
    rk_valid_d  = rk_valid_q;
    rk_d        = rk_q;
    rk_index_d  = rk_index_q;
    rk_last_d   = rk_last_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (key_valid && key_ready_q) begin
          store_d[0]  = key_w;
          rnd_d       = 4'd1;
          state_d     = EXPAND;
          key_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      EXPAND: begin
        for (int i = 1; i < 11; i++) begin
          if (rnd_q == i[3:0]) store_d[i] = next_rk;
        end
        if (rnd_q == 4'd10) begin
          // Round 10 goes straight to the output register so it is visible next cycle.
          state_d    = STREAM;
          rnd_d      = 4'd0;
          idx_d      = 4'd10;
          rk_valid_d = 1'b1;
          rk_d       = next_rk;
          rk_index_d = 4'd10;
          rk_last_d  = 1'b0;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      STREAM: begin
        if (rk_ready) begin
          if (idx_q != 4'd0) begin
            idx_d      = strm_sel;
            rk_d       = strm_rk;
            rk_index_d = strm_sel;
            rk_last_d  = (idx_q == 4'd1);
          end else begin
            state_d     = IDLE;
            rk_valid_d  = 1'b0;
            rk_index_d  = 4'd0;
            rk_last_d   = 1'b0;
            key_ready_d = 1'b1;
            busy_d      = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-key storage and output registers; reset wipes every stored key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rnd_q       <= 4'd0;
      idx_q       <= 4'd0;
      for (int i = 0; i < 11; i++) store_q[i] <= '0;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      rk_q        <= '0;
      rk_index_q  <= 4'd0;
      rk_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      idx_q       <= idx_d;
      store_q     <= store_d;
      key_ready_q <= key_ready_d;
      rk_valid_q  <= rk_valid_d;
      rk_q        <= rk_d;
      rk_index_q  <= rk_index_d;
      rk_last_q   <= rk_last_d;
      busy_q      <= busy_d;
    end
  end

  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign rk        = rk_q;
  assign rk_index  = rk_index_q;
  assign rk_last   = rk_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes128_dec_key_sched.sv
// Bench for aes128_dec_key_sched: a queue-based behavioural model fed by an
// independently derived AES key expansion (S-box built from GF(2^8) inverse
// and affine map) is compared with the DUT on every falling edge.
module tb_aes128_dec_key_sched;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_valid = 1'b0;
  logic         rk_ready = 1'b0;
  logic [0:127] key = '0;
  logic         key_ready, rk_valid, rk_last, busy;
  logic [0:127] rk;
  logic [3:0]   rk_index;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0]   sb [0:255];
  logic         m_idle = 1'b1;
  int           m_wait = 0;
  logic [127:0] m_q [$];
  int           n_acc = 0;
  int           acc_cyc [$];

  logic         bp_mode = 1'b0;
  int           stall_cnt = 0;
  logic [15:0]  stalled_mask = '0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_rk = '0;
  logic [3:0]   prev_idx = '0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  aes128_dec_key_sched dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(key_ready),
    .key(key), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk),
    .rk_index(rk_index), .rk_last(rk_last), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    for (int x = 1; x < 256; x++) if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Per-cycle comparison against the model, then advance the model by the upcoming edge.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("rst_key_ready", key_ready, 1);
      chk("rst_rk_valid", rk_valid, 0);
      chk("rst_rk", rk, 0);
      chk("rst_rk_index", rk_index, 0);
      chk("rst_rk_last", rk_last, 0);
      chk("rst_busy", busy, 0);
      m_idle = 1'b1;
      m_wait = 0;
      m_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (m_idle) begin
        chk("idle_key_ready", key_ready, 1);
        chk("idle_rk_valid", rk_valid, 0);
        chk("idle_busy", busy, 0);
      end else if (m_wait > 0) begin
        chk("exp_key_ready", key_ready, 0);
        chk("exp_rk_valid", rk_valid, 0);
        chk("exp_busy", busy, 1);
      end else begin
        chk("str_key_ready", key_ready, 0);
        chk("str_rk_valid", rk_valid, 1);
        chk("str_busy", busy, 1);
        chk("str_rk_index", rk_index, m_q.size() - 1);
        chk("str_rk", rk, m_q[0]);
        chk("str_rk_last", rk_last, (m_q.size() == 1));
      end
      if (prev_stall) begin
        chk("stall_hold_rk", rk, prev_rk);
        chk("stall_hold_idx", rk_index, prev_idx);
      end
      prev_stall = rk_valid && !rk_ready;
      prev_rk    = rk;
      prev_idx   = rk_index;
      if (m_idle) begin
        if (key_valid) begin
          m_idle = 1'b0;
          m_wait = 10;
          m_q.delete();
          for (int r = 10; r >= 0; r--) m_q.push_back(round_key(key, r));
          n_acc++;
          acc_cyc.push_back(cyc + 1);
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (rk_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_idle = 1'b1;
      end
    end
  end

  // Consumer: always ready, or random with forced 5-cycle stalls at index 10 and 0.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rk_valid) stalled_mask = '0;
    if (!bp_mode) begin
      rk_ready = 1'b1;
    end else if (stall_cnt > 0) begin
      rk_ready = 1'b0;
      stall_cnt--;
    end else if (rk_valid && (rk_index == 4'd10 || rk_index == 4'd0) && !stalled_mask[rk_index]) begin
      stalled_mask[rk_index] = 1'b1;
      stall_cnt = 4;
      rk_ready = 1'b0;
    end else begin
      rk_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_acc(input int n);
    int t;
    t = 0;
    while (n_acc < n && t < 300) begin @(negedge clk); #1; t++; end
    chk("accept_wait", (n_acc >= n), 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!m_idle && t < 500) begin @(negedge clk); #1; t++; end
    chk("idle_wait", m_idle, 1);
  endtask

  task automatic wait_idx(input logic [3:0] n);
    int t;
    t = 0;
    do begin @(negedge clk); #1; t++; end while (!(rk_valid && rk_index == n) && t < 300);
    chk("idx_wait", (rk_valid && rk_index == n), 1);
  endtask

  task automatic send_key(input logic [127:0] k);
    int n;
    n = n_acc;
    @(posedge clk); #1;
    key = k;
    key_valid = 1'b1;
    wait_acc(n + 1);
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic pulse_reset_check();
    reset = 1'b1;
    #1;
    chk("async_key_ready", key_ready, 1);
    chk("async_rk_valid", rk_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_rk", rk, 0);
    chk("async_rk_index", rk_index, 0);
    chk("async_rk_last", rk_last, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n0;
    int t;
    for (int i = 0; i < 256; i++) sb[i] = sbox_ref(8'(i));
    chk("model_sbox_00", sb[8'h00], 8'h63);
    chk("model_sbox_53", sb[8'h53], 8'hed);
    chk("model_fips_r10", round_key(FIPS_KEY, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_fips_r1", round_key(FIPS_KEY, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_seq_r10", round_key(SEQ_KEY, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Power-on reset, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("por_key_ready", key_ready, 1);
    chk("por_rk_valid", rk_valid, 0);
    chk("por_busy", busy, 0);

    // FIPS-197 key, accepted on the first edge after release.
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    key = FIPS_KEY;
    key_valid = 1'b1;
    wait_acc(1);
    chk("first_accept_cycle", acc_cyc[0], cyc + 1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    wait_idx(4'd10);
    chk("fips_latency", cyc - acc_cyc[0], 10);
    chk("fips_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_idx(4'd1);
    chk("fips_rk1", rk, 128'ha0fafe1788542cb123a339392a6c7605);
    wait_idx(4'd0);
    chk("fips_rk0", rk, FIPS_KEY);
    chk("fips_rk_last", rk_last, 1);
    wait_idle();

    // Sequential key, then confirm the block is idle again.
    send_key(SEQ_KEY);
    wait_idx(4'd10);
    chk("seq_rk10", rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    wait_idle();
    @(negedge clk); #1;
    chk("seq_done_busy", busy, 0);
    chk("seq_done_key_ready", key_ready, 1);

    // Random backpressure with stalls at both ends of the sequence.
    bp_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_key(rand128());
      wait_idle();
    end

    // A competing key held on the input throughout EXPAND and STREAM.
    n0 = n_acc;
    send_key(rand128());
    key = rand128();
    key_valid = 1'b1;
    wait_acc(n0 + 2);
    chk("competing_key_gap_ok", (acc_cyc[n0 + 1] - acc_cyc[n0] >= 22), 1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    wait_idle();

    // Reset in the middle of expansion (rnd = 5).
    bp_mode = 1'b0;
    n0 = n_acc;
    @(posedge clk); #1;
    key = rand128();
    key_valid = 1'b1;
    wait_acc(n0 + 1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_reset_busy_rnd5", busy, 1);
    pulse_reset_check();
    send_key(rand128());
    wait_idle();

    // Reset while index 3 is presented.
    bp_mode = 1'b1;
    send_key(rand128());
    t = 0;
    do begin @(posedge clk); #3; t++; end while (!(rk_valid && rk_index == 4'd3) && t < 300);
    chk("pre_reset_idx3", (rk_valid && rk_index == 4'd3), 1);
    pulse_reset_check();
    send_key(rand128());
    wait_idle();

    // Back-to-back keys with the consumer always ready.
    bp_mode = 1'b0;
    n0 = n_acc;
    @(posedge clk); #1;
    key = rand128();
    key_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_acc(n0 + j + 1);
      @(posedge clk); #1;
      key = rand128();
    end
    key_valid = 1'b0;
    for (int j = 0; j < 3; j++) chk("b2b_gap", acc_cyc[n0 + j + 1] - acc_cyc[n0 + j], 22);
    wait_idle();

    // Random keys, random gaps, random backpressure.
    bp_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_key(rand128());
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #150000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes128_dec_key_sched.md
AES128_DEC_KEY_SCHED -- requirements
Module: aes128_dec_key_sched

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; every register updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-003 SHALL have port key_valid, input, 1: a cipher key is offered on key.
REQ-004 SHALL have port key_ready, output, 1: the block can accept a key.
REQ-005 SHALL have port key, input, [0:127]: the AES-128 cipher key. Bit 0 is the MSB; byte n is bits 8n..8n+7; word w0 is bits 0..31.
REQ-006 SHALL have port rk_valid, output, 1: a round key is presented on rk.
REQ-007 SHALL have port rk_ready, input, 1: the consumer accepts rk.
REQ-008 SHALL have port rk, output, [0:127]: the round key, with the same bit ordering as key.
REQ-009 SHALL have port rk_index, output, 4: the round number (0..10) of the key on rk.
REQ-010 SHALL have port rk_last, output, 1: high while rk_index==0 and rk_valid==1.
REQ-011 SHALL have port busy, output, 1: high in the EXPAND and STREAM states.

Function
REQ-012 SHALL implement a 3-state FSM with states IDLE, EXPAND and STREAM.
REQ-013 IDLE: key_ready=1 and rk_valid=0. When key_valid&&key_ready, the block SHALL store key as round key 0, set rnd=1 and go to EXPAND.
REQ-014 EXPAND: the block SHALL compute one round key per cycle for rnd=1..10 and store it in an 11x128 register file.
- First word: w[4r] = w[4r-4] ^ SubWord(RotWord(w[4r-1])) ^ {Rcon[r],24'h0}.
- Other words: w[i] = w[i-4] ^ w[i-1].
REQ-015 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-016 SubWord SHALL use the FIPS-197 forward S-box, 4 combinational instances, one per byte.
REQ-017 After the cycle that stores round 10, the FSM SHALL go to STREAM with idx=10.
REQ-018 STREAM: rk_valid=1, rk=store[idx] and rk_index=idx.
- On rk_valid&&rk_ready with idx>0: idx decrements.
- On rk_valid&&rk_ready with idx==0: the FSM returns to IDLE.
REQ-019 Latency: if the key handshake occurs on edge T, rk_valid SHALL first be high in the cycle after edge T+10, presenting round 10.
REQ-020 Round keys SHALL be emitted strictly in order 10, 9, ..., 0; exactly 11 transfers occur per accepted key.
REQ-021 While rk_valid==1 and rk_ready==0, rk, rk_index and rk_last SHALL hold stable.
REQ-022 key_ready SHALL be 0 in EXPAND and STREAM; key_valid SHALL be ignored there and the stored keys SHALL NOT change.
REQ-023 rk_ready SHALL be ignored outside STREAM.
REQ-024 On the final (idx==0) handshake edge, key_ready SHALL still be 0; the earliest next key acceptance is the following edge.
REQ-025 rk, rk_index and rk_last SHALL be driven from registers only, with no combinational path from any input.
REQ-026 Throughput SHALL be 1 key per 22 cycles minimum: 1 accept, 10 expand, 11 stream.

Reset
REQ-027 Asserting reset SHALL immediately force:
- state=IDLE, rnd=0, idx=0, and all 11 stored round keys to 0;
- outputs key_ready=1, rk_valid=0, rk=0, rk_index=0, rk_last=0, busy=0.
REQ-028 Reset asserted mid-EXPAND or mid-STREAM SHALL discard all partial results. After release, no stale round key SHALL be emitted.
REQ-029 The first key SHALL be accepted on the first rising edge after reset deasserts, provided key_valid=1.

Verification
REQ-030 Hold key_valid=1 with key=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1.
- Response: 11 cycles after the accept edge, rk=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_index=10.
- Response: at rk_index=1, rk=a0fafe1788542cb123a339392a6c7605.
- Response: at rk_index=0, rk=2b7e...4f3c with rk_last=1.
REQ-031 Apply key=000102030405060708090a0b0c0d0e0f.
- Response: the round-10 key is 13111d7fe3944a17f307a78b4d2b30c5.
- Response: the 11 transfers complete, then busy=0 and key_ready=1.
REQ-032 Backpressure: toggle rk_ready randomly, including holding it 0 for 5 cycles at idx=10 and at idx=0.
- Response: rk and rk_index stay stable while stalled.
- Response: the sequence 10..0 completes with no skip and no repeat.
REQ-033 Drive key_valid=1 with a different key during EXPAND and during STREAM.
- Response: key_ready=0 and the output sequence is unchanged.
- Response: the new key is accepted only after the idx==0 handshake.
REQ-034 Assert reset at rnd=5 and separately at idx=3, asynchronous to clk.
- Response: outputs reach their reset values without waiting for a clock edge.
- Response: a key applied after release produces the correct full sequence.
REQ-035 Send back-to-back keys with rk_ready=1 held high.
- Response: accepts occur exactly 22 cycles apart.
- Response: each round-key sequence matches a golden FIPS-197 model.
